truth_table_probe: RTL
======================

# truth_table_probe

Sequential characterizer for 3-input combinational logic blocks such as the Wolfram-rule gates. On a start pulse it drives all 8 input rows `{in1,in2,in3}` = 0..7 into a device under test (DUT). It waits a programmable settle time per row, samples the DUT output, and reassembles the 8-bit rule code (e.g. 0x82). It sits beside a gate instance in characterization benches and self-test wrappers, as the reading end of the truth-table interface.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles each row is held; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `dut_out`  in  1  output of the DUT under test.
- `drive`  out  3  DUT inputs `{in1,in2,in3}`; bit 2 = `in1`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse; `code` is valid from this cycle onward.
- `code`  out  8  captured rule code; holds its value until the next `done`.
- `unstable`  out  1  DUT output changed within a row hold (see Configuration).

## Operation
- Reset values:
  - `drive` = 3'b000, `busy` = 0, `done` = 0, `code` = 8'h00, `unstable` = 0.
  - FSM goes to IDLE.
- FSM states: IDLE, HOLD, DONE.
  - IDLE: `busy` = 0 and `drive` = 0. When `start` = 1, row = 0 and the hold counter is cleared; next state is HOLD.
  - HOLD: `busy` = 1 and `drive` = row. The counter counts 0..`SETTLE_CYCLES`-1.
  - At the edge ending the last hold cycle of row k, `dut_out` is written into shadow bit `7-k`.
  - After that capture, if k < 7 then row increments and the counter clears. If k = 7 the next state is DONE.
  - DONE: lasts exactly one cycle. `done` = 1, `busy` = 0, `drive` = 0. `code` is loaded from the shadow register on the edge entering DONE. Next state is IDLE.
- Bit order: `code[7-k]` = DUT output for row k. For example, a DUT with outputs 1 at rows 000 and 110 and 0 elsewhere yields `code` = 8'h82.
- Boundary conditions:
  - `start` in HOLD or DONE is ignored and not queued.
  - `start` held high continuously starts a new sweep on each return to IDLE.
  - `rst` mid-sweep aborts immediately: all outputs take their reset values, the partial result is discarded, and no `done` is issued.
  - `code` is unchanged during a sweep; it updates only on DONE.
  - The row counter never wraps past 7; the sweep ends at row 7.

## Timing
- Start accepted at edge E0; `busy` = 1 and `drive` = 0 in the cycle after E0.
- Each row is presented for exactly `SETTLE_CYCLES` cycles; no gap between rows.
- `done` is high in cycle 8×`SETTLE_CYCLES`+1 after E0. With default 4, that is cycle 33.
- Earliest next accepted `start` is the edge ending the IDLE cycle that follows DONE. Minimum start-to-start spacing is 8×`SETTLE_CYCLES`+2 cycles.
- `dut_out` is treated as combinational from `drive`; no synchronizer is required. The settle time covers DUT propagation.

## Configuration
- Macro: `PROBE_STABILITY_EN`.
- With the macro defined:
  - On every hold cycle after the first in a row, `dut_out` is compared to its value in the previous cycle.
  - Any difference sets a sticky internal flag. The flag is cleared when a sweep is accepted.
  - `unstable` is loaded from the flag on the edge entering DONE and holds with `code`.
  - With `SETTLE_CYCLES` = 1 no comparison occurs, so `unstable` = 0.
- Without the macro:
  - `unstable` is tied to 0 and no comparison logic is present.
  - The port list is identical either way.

## Test plan
- DUT model = rule 0x82, `SETTLE_CYCLES` = 4: pulse `start` → `done` in cycle 33 after the accepting edge, `code` = 8'h82, `unstable` = 0.
- DUT constant 1 then constant 0 on two back-to-back sweeps → `code` = 8'hFF, then 8'h00. `code` stays 8'hFF throughout the second sweep until its `done`.
- Monitor `drive` during a sweep with `SETTLE_CYCLES` = 3 → values 0,1,…,7, each for exactly 3 cycles, then 0. `busy` is high for exactly 24 cycles.
- `start` pulsed at cycles 5 and 20 of a sweep → ignored: single `done`, timing unchanged.
- `rst` asserted while row 3 is driven → `drive`, `busy`, `code` and `done` go to reset values without waiting for a clock edge; no `done` follows. A new `start` yields the correct code.
- DUT toggling `dut_out` during row 2's third hold cycle, final value 1 → `code[5]` = 1. With `PROBE_STABILITY_EN`, `unstable` = 1; without it, `unstable` = 0. The next clean sweep (macro on) clears `unstable` to 0.

Source files
------------

// File: rtl/truth_table_probe_if.sv
// Truth-table probe bus: sweep control and status on the probe side, row drive and
// sampled response on the gate side. master = probe, slave = stimulus/gate side.
interface truth_table_probe_if;
  logic       start;
  logic       dut_out;
  logic [2:0] drive;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic       unstable;

  modport master (
    input  start,
    input  dut_out,
    output drive,
    output busy,
    output done,
    output code,
    output unstable
  );

  modport slave (
    output start,
    output dut_out,
    input  drive,
    input  busy,
    input  done,
    input  code,
    input  unstable
  );
endinterface

// File: rtl/truth_table_probe.sv
// Sweeps rows 0..7 into a 3-input gate, SETTLE_CYCLES per row, and assembles the rule code (done at cycle 8*SETTLE+1).
// start is only accepted in IDLE, never queued; optional PROBE_STABILITY_EN flags dut_out changes within a row hold.
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_probe_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] code_q, code_d;
  logic       row_end;
  logic       accept;
  logic       sweep_end;

  assign row_end   = (state_q == S_HOLD) && (cnt_q == LAST_CNT);
  assign accept    = (state_q == S_IDLE) && bus.start;
  assign sweep_end = row_end && (row_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_HOLD;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end
      end
      S_HOLD: begin
        if (row_end) begin
          // Row k lands in bit 7-k so row 000 becomes the MSB of the rule code.
          shadow_d[3'd7 - row_q] = bus.dut_out;
          if (row_q == 3'd7) begin
            state_d = S_DONE;
            code_d  = shadow_d;
          end else begin
            row_d = row_q + 3'd1;
            cnt_d = 8'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= 3'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 8'h00;
      code_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
    end
  end

  assign bus.busy  = (state_q == S_HOLD);
  assign bus.done  = (state_q == S_DONE);
  assign bus.drive = (state_q == S_HOLD) ? row_q : 3'd0;
  assign bus.code  = code_q;

`ifdef PROBE_STABILITY_EN
  logic flag_q, flag_d;
  logic prev_q, prev_d;
  logic unstable_q, unstable_d;

  // The first cycle of a row has no in-row predecessor, so it is never compared.
  always_comb begin
    flag_d     = flag_q;
    prev_d     = prev_q;
    unstable_d = unstable_q;
    if (accept) begin
      flag_d = 1'b0;
    end
    if (state_q == S_HOLD) begin
      prev_d = bus.dut_out;
      if ((cnt_q != 8'd0) && (bus.dut_out != prev_q)) begin
        flag_d = 1'b1;
      end
    end
    if (sweep_end) begin
      unstable_d = flag_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q     <= 1'b0;
      prev_q     <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      prev_q     <= prev_d;
      unstable_q <= unstable_d;
    end
  end

  assign bus.unstable = unstable_q;
`else
  logic unused_ok;
  assign unused_ok    = accept ^ sweep_end;
  assign bus.unstable = 1'b0;
`endif

endmodule
